// File: rtl/thread_scheduler_if.sv
// Fetch-scheduler bundle: front-end events and run mask in, thread grant and status out.
interface thread_scheduler_if #(
   parameter int unsigned N_THREADS = 4,
   parameter int unsigned TW        = $clog2(N_THREADS),
   parameter int unsigned CW        = 16
);
   logic                 if_stall;
   logic [N_THREADS-1:0] thread_enable;
   logic                 icache_miss_valid;
   logic [TW-1:0]        icache_miss_thread;
   logic                 icache_fill_valid;
   logic [TW-1:0]        icache_fill_thread;
   logic                 itlb_miss_valid;
   logic [TW-1:0]        itlb_miss_thread;
   logic                 tlbwrite_valid;
   logic [TW-1:0]        tlbwrite_thread;
   logic                 fetch_valid;
   logic [TW-1:0]        fetch_thread;
   logic [N_THREADS-1:0] blocked;
   logic [CW-1:0]        idle_count;

   modport master (
      output if_stall, thread_enable,
      output icache_miss_valid, icache_miss_thread, icache_fill_valid, icache_fill_thread,
      output itlb_miss_valid, itlb_miss_thread, tlbwrite_valid, tlbwrite_thread,
      input  fetch_valid, fetch_thread, blocked, idle_count
   );

   modport slave (
      input  if_stall, thread_enable,
      input  icache_miss_valid, icache_miss_thread, icache_fill_valid, icache_fill_thread,
      input  itlb_miss_valid, itlb_miss_thread, tlbwrite_valid, tlbwrite_thread,
      output fetch_valid, fetch_thread, blocked, idle_count
   );
endinterface

// File: rtl/thread_scheduler.sv
// Round-robin fetch-thread scheduler: per-thread miss/wait FSMs, circular grant
// from the last granted thread, selection held on front-end stall.
module thread_scheduler #(
   parameter int unsigned N_THREADS = 4,
   parameter int unsigned TW        = $clog2(N_THREADS),
   parameter int unsigned CW        = 16
) (
   input logic               clk,
   input logic               rst,
   thread_scheduler_if.slave bus
);
   typedef enum logic [1:0] {READY, WAIT_IC, WAIT_TLB} state_e;

   state_e               state_q [N_THREADS];
   state_e               state_d [N_THREADS];
   logic [N_THREADS-1:0] eligible;
   logic [N_THREADS-1:0] blocked;
   logic [TW-1:0]        cand;
   logic                 grant_valid;
   logic [TW-1:0]        grant_id;

   logic                 fetch_valid_q, fetch_valid_d;
   logic [TW-1:0]        fetch_thread_q, fetch_thread_d;
   logic [TW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        idle_q, idle_d;

   // ITLB miss beats I-cache miss beats release; an I-cache miss never demotes WAIT_TLB.
   always_comb begin
      eligible = '0;
      for (int unsigned k = 0; k < N_THREADS; k++) begin
         state_d[k] = state_q[k];
         if (bus.itlb_miss_valid && bus.itlb_miss_thread == TW'(k)) begin
            state_d[k] = WAIT_TLB;
         end else if (bus.icache_miss_valid && bus.icache_miss_thread == TW'(k)) begin
            if (state_q[k] != WAIT_TLB) state_d[k] = WAIT_IC;
         end else if (state_q[k] == WAIT_IC && bus.icache_fill_valid &&
                      bus.icache_fill_thread == TW'(k)) begin
            state_d[k] = READY;
         end else if (state_q[k] == WAIT_TLB && bus.tlbwrite_valid &&
                      bus.tlbwrite_thread == TW'(k)) begin
            state_d[k] = READY;
         end
         eligible[k] = (state_d[k] == READY) && bus.thread_enable[k];
      end
   end

   // Offset N_THREADS wraps to ptr itself, so a lone eligible ptr thread is re-granted.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = ptr_q;
      cand        = '0;
      for (int unsigned i = 1; i <= N_THREADS; i++) begin
         cand = ptr_q + TW'(i);
         if (!grant_valid && eligible[cand]) begin
            grant_valid = 1'b1;
            grant_id    = cand;
         end
      end
   end

   always_comb begin
      fetch_valid_d  = fetch_valid_q;
      fetch_thread_d = fetch_thread_q;
      ptr_d          = ptr_q;
      idle_d         = idle_q;
      if (!bus.if_stall) begin
         fetch_valid_d = grant_valid;
         if (grant_valid) begin
            fetch_thread_d = grant_id;
            ptr_d          = grant_id;
         end else if (idle_q != '1) begin
            idle_d = idle_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < N_THREADS; k++) state_q[k] <= READY;
         fetch_valid_q  <= 1'b0;
         fetch_thread_q <= '0;
         ptr_q          <= TW'(N_THREADS - 1);
         idle_q         <= '0;
      end else begin
         for (int unsigned k = 0; k < N_THREADS; k++) state_q[k] <= state_d[k];
         fetch_valid_q  <= fetch_valid_d;
         fetch_thread_q <= fetch_thread_d;
         ptr_q          <= ptr_d;
         idle_q         <= idle_d;
      end
   end

   always_comb begin
      blocked = '0;
      for (int unsigned k = 0; k < N_THREADS; k++) blocked[k] = (state_q[k] != READY);
   end

   assign bus.fetch_valid  = fetch_valid_q;
   assign bus.fetch_thread = fetch_thread_q;
   assign bus.blocked      = blocked;
   assign bus.idle_count   = idle_q;
endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

Round-robin fetch-thread scheduler for the multithreaded front end. Every cycle it selects which hardware thread the IF stage fetches for, and presents that thread as `if_thread` into the IFID/IDEX path. It tracks, per thread, whether the thread is waiting on an instruction-cache fill or an ITLB write, and skips blocked or disabled threads. It holds its selection while the front end is stalled.

## Interface
Parameters:
- `N_THREADS`, default `common::n_threads` (4): number of hardware threads; power of two, at least 2.
- `TW`, default `$clog2(N_THREADS)`: thread-id width, equal to the width of `threadid_t`.
- `CW`, default 16: width of the idle-cycle counter.

Ports:
- `clk` input 1: single clock; everything is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `if_stall` input 1: front end frozen; hold the current selection.
- `thread_enable` input N_THREADS: per-thread run mask; 0 means the thread is never selected.
- `icache_miss_valid` input 1: a fetch missed in the I-cache.
- `icache_miss_thread` input TW: owner of that miss.
- `icache_fill_valid` input 1: the I-cache fill has completed.
- `icache_fill_thread` input TW: owner of that fill.
- `itlb_miss_valid` input 1: a fetch missed in the ITLB.
- `itlb_miss_thread` input TW: owner of that ITLB miss.
- `tlbwrite_valid` input 1: an ITLB entry has been written.
- `tlbwrite_thread` input TW: thread the entry was written for.
- `fetch_valid` output 1: `fetch_thread` is a legal fetch this cycle.
- `fetch_thread` output TW: selected thread; drives `if_thread`.
- `blocked` output N_THREADS: 1 means the thread is in a WAIT state.
- `idle_count` output CW: saturating count of unstalled cycles with `fetch_valid`=0.

## Operation
- Each thread has its own 3-state FSM: READY, WAIT_IC, WAIT_TLB. Encoding is free.
- Transitions:
  - READY -> WAIT_TLB on an ITLB miss for this thread.
  - READY -> WAIT_IC on an I-cache miss for this thread.
  - WAIT_IC -> READY on an I-cache fill for this thread.
  - WAIT_TLB -> READY on a TLB write for this thread.
  - A fill or TLB write that does not match the thread's current WAIT state is ignored.
- Priority for the same thread in the same cycle, highest first:
  1. ITLB miss.
  2. I-cache miss.
  3. Release (fill or TLB write).
- A miss arriving while the thread is already in a WAIT state moves it to the state of the higher-priority event. WAIT_IC plus an ITLB miss gives WAIT_TLB. WAIT_TLB plus an I-cache miss stays WAIT_TLB.
- `blocked[k]` is the registered FSM state of thread k, not READY.
- Eligibility: thread k is eligible if its next-state is READY and `thread_enable[k]`=1.
- Selection: the first eligible thread searching circularly from `ptr+1` to `ptr`, where `ptr` is the last granted thread.
  - If there is a winner: `fetch_valid`<=1, `fetch_thread`<=winner, `ptr`<=winner.
  - If there is none: `fetch_valid`<=0; `fetch_thread` and `ptr` keep their values.
- `if_stall`=1:
  - `fetch_valid`, `fetch_thread` and `ptr` hold their values.
  - FSMs still update from events.
  - `idle_count` does not count.
- `idle_count` increments when `if_stall`=0 and the newly registered `fetch_valid` is 0. It saturates at 2^CW-1.

## Timing
- Reset values (asynchronous, on `rst`=0):
  - All FSMs READY.
  - `ptr`=N_THREADS-1, so thread 0 is granted first.
  - `fetch_valid`=0, `fetch_thread`=0, `blocked`=0, `idle_count`=0.
- The first possible grant appears one cycle after `rst` deasserts.
- All outputs are registered. An event or enable change sampled at edge t affects `fetch_thread`/`fetch_valid`/`blocked` from edge t onward, visible in cycle t+1. A thread missing at edge t is never granted in cycle t+1.
- Release latency: a fill or TLB write sampled at edge t makes the thread grantable in cycle t+1.
- When the only eligible thread is the one in `ptr`, it is re-granted every cycle.
- Stall release: the first edge with `if_stall`=0 performs a fresh selection, using the held `ptr`.
- Reset mid-miss: all WAIT states are discarded and outstanding releases are not remembered. The memory side must also be reset.

## Test plan
- Reset with all 4 threads enabled, no events -> `fetch_thread` goes 0,1,2,3,0,… from the first cycle after reset; `fetch_valid`=1 throughout; `idle_count`=0.
- I-cache miss for thread 1 at cycle 5, fill at cycle 12 -> `blocked`=4'b0010 during cycles 6-12; sequence skips 1 (…0,2,3,0,2…); thread 1 is eligible again from cycle 13.
- ITLB miss and I-cache miss for thread 2 in the same cycle, then an I-cache fill for thread 2 -> stays WAIT_TLB and is not granted; a TLB write for thread 2 -> granted again the next cycle.
- `thread_enable`=4'b0001 with thread 0 blocked -> `fetch_valid`=0 and `idle_count` increments each cycle; force 2^16 idle cycles -> `idle_count` sticks at 16'hFFFF.
- Assert `if_stall` for 3 cycles while `fetch_thread`=2, with thread 3 missing during the stall -> outputs hold 2; after the stall the grant is 0 (3 is skipped).
- Drop `rst` while thread 1 is in WAIT_IC and `fetch_thread`=3 -> `fetch_valid`=0, `fetch_thread`=0 and `blocked`=0 immediately (asynchronously); after release, grants restart at 0.
